// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit that sits between the execute stage and the
// data memory. It aligns store data onto byte lanes, generates store byte
// enables, runs a request/acknowledge handshake with the memory (bounded by
// an ack timeout), and sign/zero-extends load data for writeback. The
// upstream pipeline is held for as long as an access is in flight.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   ex_valid/ex_is_load/
//   ex_is_store/ex_funct3/
//   ex_addr/ex_st_data       instruction presented by the execute stage
//   lsu_stall                combinational hold request to the pipeline
//   ld_data, ld_valid        registered load result and its one-cycle pulse
//   lsu_exc                  one-cycle pulse for a misaligned/illegal access
//   bus_err                  one-cycle pulse when the memory never acks
//   dmem_req/we/addr/be/wdata  request to data memory, stable while BUSY
//   dmem_ack, dmem_rdata     completion and read data from data memory
module lsu_ctrl #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_st_data,
  output logic        lsu_stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        lsu_exc,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [29:0]   lat_addr;
  logic [1:0]    lat_off;
  logic [2:0]    lat_funct3;
  logic          lat_we;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;
  logic [CW-1:0] cnt;

  logic          mem_op;
  logic          illegal;
  logic          misaligned;
  logic          accept;
  logic          exc_req;
  logic          timeout;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;

  // Shift the addressed byte/halfword down to bit 0 and extend it to 32 bits.
  // Only the low 16 bits of the shifted word are ever needed.
  function automatic logic [31:0] extend(input logic [2:0]  f3,
                                         input logic [1:0]  off,
                                         input logic [31:0] rdata);
    logic [15:0] s;
    s = 16'(rdata >> {off, 3'b000});
    case (f3)
      3'b000:  extend = {{24{s[7]}}, s[7:0]};
      3'b100:  extend = {24'h0, s[7:0]};
      3'b001:  extend = {{16{s[15]}}, s[15:0]};
      3'b101:  extend = {16'h0, s[15:0]};
      default: extend = rdata;
    endcase
  endfunction

  // Decode the execute-stage instruction: is it a memory op, is it illegal
  // (both load and store, or an unsupported width), is it misaligned, and
  // what byte enables and lane-replicated data would a store use.
  always_comb begin
    mem_op     = ex_valid & (ex_is_load ^ ex_is_store);
    illegal    = 1'b0;
    misaligned = 1'b0;
    st_be      = 4'b1111;
    st_wdata   = ex_st_data;

    if (ex_valid & ex_is_load & ex_is_store)
      illegal = 1'b1;
    else if (ex_is_load)
      illegal = (ex_funct3 == 3'b011) | (ex_funct3 == 3'b110) |
                (ex_funct3 == 3'b111);
    else if (ex_is_store)
      illegal = (ex_funct3 > 3'b010);

    if (ex_is_load | ex_is_store) begin
      case (ex_funct3)
        3'b001, 3'b101: misaligned = ex_addr[0];
        3'b010:         misaligned = (ex_addr[1:0] != 2'b00);
        default:        misaligned = 1'b0;
      endcase
    end

    if (ex_is_store) begin
      case (ex_funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << ex_addr[1:0];
          st_wdata = {4{ex_st_data[7:0]}};
        end
        2'b01: begin
          st_be    = 4'b0011 << ex_addr[1:0];
          st_wdata = {2{ex_st_data[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = ex_st_data;
        end
      endcase
    end

    accept  = (state == IDLE) & mem_op & ~illegal & ~misaligned;
    exc_req = (state == IDLE) & ex_valid & (illegal | (mem_op & misaligned));
    timeout = (state == BUSY) & ~dmem_ack & (cnt == CW'(ACK_TIMEOUT - 1));
  end

  // Next-state logic and the combinational handshake outputs. The stall is
  // raised in the accept cycle already so the instruction behind the access
  // does not advance, and stays up through the ack/timeout cycle.
  always_comb begin
    state_nxt = state;
    lsu_stall = 1'b0;
    dmem_req  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          lsu_stall = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        lsu_stall = 1'b1;
        dmem_req  = 1'b1;
        if (dmem_ack | timeout)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register. Reset during BUSY simply drops back to IDLE, so a late
  // ack from memory lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Request latches, timeout counter and the registered result pulses.
  // The pulses default low every cycle; reset takes priority so an aborted
  // access produces neither ld_valid nor bus_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr   <= '0;
      lat_off    <= '0;
      lat_funct3 <= '0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      ld_data    <= '0;
      ld_valid   <= 1'b0;
      lsu_exc    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      lsu_exc  <= 1'b0;
      bus_err  <= 1'b0;

      if (accept) begin
        lat_addr   <= ex_addr[31:2];
        lat_off    <= ex_addr[1:0];
        lat_funct3 <= ex_funct3;
        lat_we     <= ex_is_store;
        lat_be     <= st_be;
        lat_wdata  <= st_wdata;
        cnt        <= '0;
      end

      if (exc_req)
        lsu_exc <= 1'b1;

      if (state == BUSY) begin
        if (dmem_ack) begin
          if (!lat_we) begin
            ld_data  <= extend(lat_funct3, lat_off, dmem_rdata);
            ld_valid <= 1'b1;
          end
        end else if (timeout) begin
          bus_err <= 1'b1;
          if (!lat_we) begin
            ld_data  <= '0;
            ld_valid <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign dmem_we    = lat_we;
  assign dmem_addr  = {lat_addr, 2'b00};
  assign dmem_be    = lat_be;
  assign dmem_wdata = lat_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl. Inputs are driven
// and outputs sampled on the falling clock edge, half a period away from the
// rising edge where the design updates.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_st_data;
  logic        lsu_stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        lsu_exc;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int checks;
  int failures;

  lsu_ctrl #(.ACK_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_is_store (ex_is_store),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_st_data  (ex_st_data),
    .lsu_stall   (lsu_stall),
    .ld_data     (ld_data),
    .ld_valid    (ld_valid),
    .lsu_exc     (lsu_exc),
    .bus_err     (bus_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one instruction from the execute stage.
  task automatic drive_ex(input logic v, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
    ex_valid    = v;
    ex_is_load  = ld;
    ex_is_store = st;
    ex_funct3   = f3;
    ex_addr     = a;
    ex_st_data  = d;
  endtask

  // Reset values, then a stray ack after reset must be ignored.
  task automatic test_reset();
    rst = 1'b1;
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_req: got %b expected 0", dmem_req);
    end
    checks++;
    if (ld_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_ld_data: got %h expected 00000000", ld_data);
    end
    checks++;
    if ({ld_valid, lsu_exc, bus_err, lsu_stall} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_pulses: got %b expected 0000",
               {ld_valid, lsu_exc, bus_err, lsu_stall});
    end
    rst        = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++;
    if ({ld_valid, bus_err, dmem_req, ld_data} !== {3'b000, 32'h0}) begin
      failures++;
      $display("[TB] FAIL stray_ack: got v=%b e=%b r=%b d=%h expected 0 0 0 00000000",
               ld_valid, bus_err, dmem_req, ld_data);
    end
  endtask

  // Loads acked in the first BUSY cycle: accept c0, ack c1, ld_valid c2.
  task automatic test_loads();
    logic [2:0]  f3s  [6] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010, 3'b000};
    logic [31:0] adrs [6] = '{32'h103, 32'h102, 32'h102, 32'h001, 32'h104, 32'h002};
    logic [31:0] rds  [6] = '{32'h80FF_1234, 32'hBEEF_0000, 32'hBEEF_0000,
                              32'h0000_8000, 32'hDEAD_BEEF, 32'h0045_0000};
    logic [31:0] exps [6] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_BEEF,
                              32'h0000_0080, 32'hDEAD_BEEF, 32'h0000_0045};
    logic [31:0] waddr [6] = '{32'h100, 32'h100, 32'h100, 32'h000, 32'h104, 32'h000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_ex(1'b1, 1'b1, 1'b0, f3s[i], adrs[i], 32'h5555_5555);
      #1;
      checks++;
      if ({lsu_stall, dmem_req} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL load%0d_accept: got stall/req=%b expected 10", i,
                 {lsu_stall, dmem_req});
      end
      @(negedge clk);
      drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      checks++;
      if ({dmem_req, dmem_we, dmem_be, dmem_addr, lsu_stall} !==
          {1'b1, 1'b0, 4'b1111, waddr[i], 1'b1}) begin
        failures++;
        $display("[TB] FAIL load%0d_busy: got req=%b we=%b be=%b addr=%h stall=%b expected 1 0 1111 %h 1",
                 i, dmem_req, dmem_we, dmem_be, dmem_addr, lsu_stall, waddr[i]);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = rds[i];
      @(negedge clk);
      dmem_ack = 1'b0;
      checks++;
      if ({ld_valid, ld_data, lsu_stall, dmem_req} !== {1'b1, exps[i], 2'b00}) begin
        failures++;
        $display("[TB] FAIL load%0d_result: got v=%b d=%h stall=%b req=%b expected 1 %h 0 0",
                 i, ld_valid, ld_data, lsu_stall, dmem_req, exps[i]);
      end
      @(negedge clk);
      checks++;
      if (ld_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL load%0d_pulse: got ld_valid=%b expected 0", i, ld_valid);
      end
    end
  endtask

  // Stores acked after two BUSY cycles; request must stay stable, no ld_valid
  // and ld_data keeps the last load result (0x45).
  task automatic test_stores();
    logic [2:0]  f3s  [4] = '{3'b001, 3'b000, 3'b010, 3'b000};
    logic [31:0] adrs [4] = '{32'h202, 32'h301, 32'h400, 32'h303};
    logic [31:0] dats [4] = '{32'h1234_ABCD, 32'h0000_005A, 32'hCAFE_F00D, 32'hAB12_3477};
    logic [3:0]  bes  [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
    logic [31:0] wds  [4] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_F00D, 32'h7777_7777};
    logic [31:0] was  [4] = '{32'h200, 32'h300, 32'h400, 32'h300};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_ex(1'b1, 1'b0, 1'b1, f3s[i], adrs[i], dats[i]);
      @(negedge clk);
      drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !==
            {1'b1, 1'b1, bes[i], was[i], wds[i]}) begin
          failures++;
          $display("[TB] FAIL store%0d_req%0d: got req=%b we=%b be=%b addr=%h wd=%h expected 1 1 %b %h %h",
                   i, k, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
                   bes[i], was[i], wds[i]);
        end
        if (k == 1) dmem_ack = 1'b1;
        @(negedge clk);
      end
      dmem_ack = 1'b0;
      checks++;
      if ({ld_valid, ld_data, dmem_req, lsu_stall} !== {1'b0, 32'h45, 2'b00}) begin
        failures++;
        $display("[TB] FAIL store%0d_done: got v=%b d=%h req=%b stall=%b expected 0 00000045 0 0",
                 i, ld_valid, ld_data, dmem_req, lsu_stall);
      end
    end
  endtask

  // Misaligned and illegal accesses: exception pulse, no request, no stall.
  task automatic test_exceptions();
    logic        lds [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        sts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b011, 3'b000, 3'b100};
    logic [31:0] ads [5] = '{32'h101, 32'h103, 32'h000, 32'h000, 32'h000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_ex(1'b1, lds[i], sts[i], f3s[i], ads[i], 32'h0);
      #1;
      checks++;
      if ({lsu_stall, dmem_req} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL exc%0d_nostall: got stall/req=%b expected 00", i,
                 {lsu_stall, dmem_req});
      end
      @(negedge clk);
      drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      checks++;
      if ({lsu_exc, dmem_req, ld_valid} !== 3'b100) begin
        failures++;
        $display("[TB] FAIL exc%0d_pulse: got exc/req/v=%b expected 100", i,
                 {lsu_exc, dmem_req, ld_valid});
      end
      @(negedge clk);
      checks++;
      if ({lsu_exc, dmem_req} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL exc%0d_clear: got exc/req=%b expected 00", i,
                 {lsu_exc, dmem_req});
      end
    end
  endtask

  // A misaligned instruction presented while BUSY must be ignored.
  task automatic test_ignore_busy();
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if ({dmem_req, dmem_addr, lsu_exc} !== {1'b1, 32'h104, 1'b0}) begin
      failures++;
      $display("[TB] FAIL busy_ignore: got req=%b addr=%h exc=%b expected 1 00000104 0",
               dmem_req, dmem_addr, lsu_exc);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1122_3344;
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++;
    if ({ld_valid, ld_data, lsu_exc} !== {1'b1, 32'h1122_3344, 1'b0}) begin
      failures++;
      $display("[TB] FAIL busy_result: got v=%b d=%h exc=%b expected 1 11223344 0",
               ld_valid, ld_data, lsu_exc);
    end
  endtask

  // No ack at all: 16 BUSY cycles, then bus_err with a zeroed load result.
  task automatic test_timeout();
    int busy_cycles;
    busy_cycles = 0;
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 1'b0, 3'b010, 32'h010, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      if (dmem_req !== 1'b1) break;
      busy_cycles++;
    end
    checks++;
    if (busy_cycles != 16) begin
      failures++;
      $display("[TB] FAIL timeout_cycles: got %0d expected 16", busy_cycles);
    end
    checks++;
    if ({bus_err, ld_valid, ld_data, lsu_stall} !== {2'b11, 32'h0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL timeout_result: got err=%b v=%b d=%h stall=%b expected 1 1 00000000 0",
               bus_err, ld_valid, ld_data, lsu_stall);
    end
    @(negedge clk);
    checks++;
    if ({bus_err, ld_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL timeout_pulse: got err/v=%b expected 00", {bus_err, ld_valid});
    end
  endtask

  // Reset in BUSY cycle 2 aborts the access; the late ack is ignored.
  task automatic test_reset_mid_busy();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 1'b0, 3'b010, 32'h020, 32'h0);
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({dmem_req, ld_valid, bus_err, lsu_stall} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL rst_abort: got req/v/err/stall=%b expected 0000",
               {dmem_req, ld_valid, bus_err, lsu_stall});
    end
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h9999_9999;
    @(negedge clk);
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ld_valid | bus_err | dmem_req) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({seen, ld_data} !== {1'b0, 32'h0}) begin
      failures++;
      $display("[TB] FAIL rst_late_ack: got activity=%b d=%h expected 0 00000000",
               seen, ld_data);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_loads();
    test_stores();
    test_exceptions();
    test_ignore_busy();
    test_timeout();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
